// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: requests instructions at the PC, hands them to decode,
// then commands the PC block (increment, absolute load or relative add). Optional FETCH_TIMEOUT_EN.
module fetch_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] pc_addr,
    output logic [2:0]  pc_drive,
    output logic [31:0] pc_set,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        br_req,
    input  logic        br_rel,
    input  logic [31:0] br_target,
    input  logic        halt_req,
    output logic        busy,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ISSUE,
        S_UPDATE,
        S_HALT
    } state_t;

    localparam logic [2:0] PC_HOLD = 3'b000;
    localparam logic [2:0] PC_INC  = 3'b001;
    localparam logic [2:0] PC_LOAD = 3'b011;
    localparam logic [2:0] PC_ADD  = 3'b100;

    state_t      state_reg, state_next;
    logic [31:0] addr_reg;
    logic [31:0] instr_reg;
    logic        br_pend_reg;
    logic        br_rel_reg;
    logic [31:0] br_tgt_reg;
    logic        halt_reg;

`ifdef FETCH_TIMEOUT_EN
    logic [7:0]  cnt_reg;
    logic        fault_reg;
    logic        timeout;
`endif

    always_comb begin
        state_next  = state_reg;
        pc_drive    = PC_HOLD;
        pc_set      = 32'd0;
        mem_req     = 1'b0;
        mem_addr    = addr_reg;
        instr_valid = 1'b0;
        busy        = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        timeout     = 1'b0;
`endif
        case (state_reg)
            S_IDLE: begin
                if (start)
                    state_next = S_REQ;
            end
            S_REQ: begin
                mem_req    = 1'b1;
                mem_addr   = pc_addr;
                busy       = 1'b1;
                state_next = mem_ack ? S_ISSUE : S_WAIT;
            end
            S_WAIT: begin
                mem_req = 1'b1;
                busy    = 1'b1;
                if (mem_ack) begin
                    state_next = S_ISSUE;
                end
`ifdef FETCH_TIMEOUT_EN
                // 255th consecutive WAIT cycle without an acknowledge
                else if (cnt_reg == 8'd254) begin
                    timeout    = 1'b1;
                    state_next = S_HALT;
                end
`endif
            end
            S_ISSUE: begin
                instr_valid = 1'b1;
                busy        = 1'b1;
                if (instr_ready)
                    state_next = S_UPDATE;
            end
            S_UPDATE: begin
                busy = 1'b1;
                if (br_pend_reg) begin
                    pc_set   = br_tgt_reg;
                    pc_drive = br_rel_reg ? PC_ADD : PC_LOAD;
                end else begin
                    pc_drive = PC_INC;
                end
                state_next = (halt_reg || halt_req) ? S_HALT : S_REQ;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= S_IDLE;
            addr_reg    <= 32'd0;
            instr_reg   <= 32'd0;
            br_pend_reg <= 1'b0;
            br_rel_reg  <= 1'b0;
            br_tgt_reg  <= 32'd0;
            halt_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_REQ)
                addr_reg <= pc_addr;
            if ((state_reg == S_REQ || state_reg == S_WAIT) && mem_ack)
                instr_reg <= mem_data;
            // branch info is only meaningful alongside the decode handshake
            if (state_reg == S_ISSUE && instr_ready) begin
                br_pend_reg <= br_req;
                br_rel_reg  <= br_rel;
                br_tgt_reg  <= br_target;
            end else if (state_reg == S_UPDATE) begin
                br_pend_reg <= 1'b0;
            end
            if (halt_req && state_reg != S_IDLE)
                halt_reg <= 1'b1;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg   <= 8'd0;
            fault_reg <= 1'b0;
        end else begin
            if (state_reg == S_REQ)
                cnt_reg <= 8'd0;
            else if (state_reg == S_WAIT && !mem_ack)
                cnt_reg <= cnt_reg + 8'd1;
            if (timeout)
                fault_reg <= 1'b1;
        end
    end
    assign fault = fault_reg;
`else
    assign fault = 1'b0;
`endif

    assign instr = instr_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a behavioural PC block closing the pc_drive loop.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] pc_addr;
    logic [2:0]  pc_drive;
    logic [31:0] pc_set;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        br_req;
    logic        br_rel;
    logic [31:0] br_target;
    logic        halt_req;
    logic        busy;
    logic        fault;

    logic        pc_load;
    logic [31:0] pc_load_val;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .pc_addr(pc_addr),
        .pc_drive(pc_drive), .pc_set(pc_set), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_data(mem_data), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .br_req(br_req), .br_rel(br_rel), .br_target(br_target),
        .halt_req(halt_req), .busy(busy), .fault(fault)
    );

    // PC block model: increment by one, absolute load, relative add
    always @(posedge clk) begin
        if (pc_load)
            pc_addr <= pc_load_val;
        else case (pc_drive)
            3'b001:  pc_addr <= pc_addr + 32'd1;
            3'b011:  pc_addr <= pc_set;
            3'b100:  pc_addr <= pc_addr + pc_set;
            default: pc_addr <= pc_addr;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; mem_ack = 1'b0; mem_data = 32'd0;
        instr_ready = 1'b0; br_req = 1'b0; br_rel = 1'b0; br_target = 32'd0;
        halt_req = 1'b0; pc_load = 1'b1; pc_load_val = 32'd0;
        #1;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_pc_drive", {29'd0, pc_drive}, 32'd0);
        chk("rst_pc_set", pc_set, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        tick(); tick();
        rst = 1'b1; pc_load = 1'b0;
        tick();
        chk("idle_no_start", {31'd0, busy}, 32'd0);

        // zero-wait fetch, increment
        start = 1'b1; mem_ack = 1'b1; mem_data = 32'hA5A5A5A5; instr_ready = 1'b1;
        tick();
        chk("t1_req", {31'd0, mem_req}, 32'd1);
        chk("t1_addr", mem_addr, 32'd0);
        start = 1'b0;
        tick();
        chk("t1_valid", {31'd0, instr_valid}, 32'd1);
        chk("t1_instr", instr, 32'hA5A5A5A5);
        chk("t1_req_low", {31'd0, mem_req}, 32'd0);
        chk("t1_hold", {29'd0, pc_drive}, 32'd0);
        mem_ack = 1'b0; mem_data = 32'h0;
        tick();
        chk("t1_valid_off", {31'd0, instr_valid}, 32'd0);
        chk("t1_inc", {29'd0, pc_drive}, 32'd1);
        chk("t1_pc_set", pc_set, 32'd0);
        tick();
        chk("t1_drive_once", {29'd0, pc_drive}, 32'd0);
        chk("t1_next_addr", mem_addr, 32'd1);

        // memory waits 4 cycles, decode stalls 3 cycles
        instr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t2_wait_req", {31'd0, mem_req}, 32'd1);
            chk("t2_wait_addr", mem_addr, 32'd1);
            pc_load = (i == 0); pc_load_val = 32'h40;
            if (i == 3) begin
                mem_ack = 1'b1; mem_data = 32'h12345678;
            end
        end
        tick();
        chk("t2_req_low", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b0; mem_data = 32'hFFFF0000;
        for (int j = 0; j < 3; j++) begin
            chk("t2_stall_valid", {31'd0, instr_valid}, 32'd1);
            chk("t2_stall_instr", instr, 32'h12345678);
            chk("t2_stall_hold", {29'd0, pc_drive}, 32'd0);
            tick();
        end
        chk("t2_valid4", {31'd0, instr_valid}, 32'd1);
        instr_ready = 1'b1;
        tick();
        chk("t2_inc", {29'd0, pc_drive}, 32'd1);
        tick();
        chk("t2_drive_once", {29'd0, pc_drive}, 32'd0);
        chk("t2_next_addr", mem_addr, 32'h41);

        // absolute branch; br_req outside handshake must be dropped
        mem_ack = 1'b1; mem_data = 32'h0BAD0001;
        br_req = 1'b1; br_rel = 1'b1; br_target = 32'hDEAD;
        tick();
        br_rel = 1'b0; br_target = 32'h100;
        tick();
        chk("t3_abs_drive", {29'd0, pc_drive}, 32'd3);
        chk("t3_abs_set", pc_set, 32'h100);
        br_req = 1'b0; br_target = 32'h999;
        tick();
        chk("t3_abs_addr", mem_addr, 32'h100);
        tick();
        br_req = 1'b1; br_rel = 1'b1; br_target = 32'hFFFFFFFC;
        tick();
        chk("t3_rel_drive", {29'd0, pc_drive}, 32'd4);
        chk("t3_rel_set", pc_set, 32'hFFFFFFFC);
        br_req = 1'b0;
        tick();
        chk("t3_rel_addr", mem_addr, 32'hFC);
        br_req = 1'b1; br_rel = 1'b0; br_target = 32'h777;
        tick();
        br_req = 1'b0;
        tick();
        br_req = 1'b1;
        chk("t3_ign_drive", {29'd0, pc_drive}, 32'd1);
        chk("t3_ign_set", pc_set, 32'd0);
        tick();
        br_req = 1'b0;
        chk("t3_ign_addr", mem_addr, 32'hFD);

        // halt request while waiting on memory
        mem_ack = 1'b0;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0; mem_ack = 1'b1; mem_data = 32'hCAFEF00D;
        tick();
        chk("t4_instr", instr, 32'hCAFEF00D);
        mem_ack = 1'b0;
        tick();
        chk("t4_inc", {29'd0, pc_drive}, 32'd1);
        chk("t4_busy_upd", {31'd0, busy}, 32'd1);
        tick();
        chk("t4_halt_busy", {31'd0, busy}, 32'd0);
        chk("t4_halt_req", {31'd0, mem_req}, 32'd0);
        chk("t4_halt_drive", {29'd0, pc_drive}, 32'd0);
        start = 1'b1;
        tick(); tick();
        chk("t4_start_ign_busy", {31'd0, busy}, 32'd0);
        chk("t4_start_ign_req", {31'd0, mem_req}, 32'd0);
        start = 1'b0;

        // reset in the middle of a WAIT, memory acknowledges late
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_req", {31'd0, mem_req}, 32'd1);
        tick();
        chk("t5_wait", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("t5_req_async", {31'd0, mem_req}, 32'd0);
        chk("t5_busy_async", {31'd0, busy}, 32'd0);
        mem_ack = 1'b1; mem_data = 32'h11112222;
        tick();
        chk("t5_late_valid", {31'd0, instr_valid}, 32'd0);
        rst = 1'b1;
        tick();
        chk("t5_idle_valid", {31'd0, instr_valid}, 32'd0);
        chk("t5_idle_busy", {31'd0, busy}, 32'd0);
        chk("t5_idle_instr", instr, 32'd0);
        mem_ack = 1'b0;

        // memory never answers
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef FETCH_TIMEOUT_EN
        for (int k = 0; k < 255; k++) begin
            tick();
            if (k == 254)
                chk("t6_last_wait", {31'd0, mem_req}, 32'd1);
        end
        tick();
        chk("t6_fault", {31'd0, fault}, 32'd1);
        chk("t6_req_off", {31'd0, mem_req}, 32'd0);
        chk("t6_busy_off", {31'd0, busy}, 32'd0);
        chk("t6_drive", {29'd0, pc_drive}, 32'd0);
`else
        repeat (1000) tick();
        chk("t6_req_held", {31'd0, mem_req}, 32'd1);
        chk("t6_busy_held", {31'd0, busy}, 32'd1);
        chk("t6_no_fault", {31'd0, fault}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-low.
REQ-003 start  in  1  leave IDLE and begin fetching; sampled in IDLE only.
REQ-004 pc_addr  in  32  current program counter value from the PC block.
REQ-005 pc_drive  out  3  PC command: 000 hold, 001 increment, 011 load pc_set, 100 add pc_set; 010 SHALL never be issued.
REQ-006 pc_set  out  32  branch target or offset accompanying pc_drive 011/100.
REQ-007 mem_req  out  1  instruction memory read request; mem_addr  out  32  read address.
REQ-008 mem_ack  in  1  read complete; mem_data  in  32  read data, valid with mem_ack.
REQ-009 instr  out  32 and instr_valid  out  1  fetched instruction toward decode; instr_ready  in  1  decode accepts.
REQ-010 br_req  in  1, br_rel  in  1, br_target  in  32  branch request, 1 = relative, target or offset.
REQ-011 halt_req  in  1  stop after current instruction; busy  out  1  not IDLE/HALT; fault  out  1  fetch timeout.

Function
REQ-012 FSM states SHALL be IDLE, REQ, WAIT, ISSUE, UPDATE, HALT.
REQ-013 IDLE: start=1 -> REQ; otherwise stay; outputs inactive.
REQ-014 REQ: mem_req=1, mem_addr=pc_addr; mem_ack=1 in the same cycle -> latch mem_data into instr, go ISSUE; otherwise -> WAIT.
REQ-015 WAIT: mem_req held 1, mem_addr held; mem_ack=1 -> latch mem_data, go ISSUE, mem_req low on the next cycle.
REQ-016 ISSUE: instr_valid=1, instr stable until instr_valid & instr_ready; handshake -> UPDATE.
REQ-017 br_req/br_rel/br_target SHALL be sampled only in the ISSUE handshake cycle and held in a pending register; br_req at any other time SHALL be ignored.
REQ-018 UPDATE, one cycle only: pending branch with br_rel=1 -> pc_drive=100, pc_set=offset; br_rel=0 -> pc_drive=011, pc_set=target; no branch -> pc_drive=001, pc_set=0.
REQ-019 pc_drive SHALL be 000 and pc_set 0 in every state except UPDATE.
REQ-020 After UPDATE, the next state SHALL be REQ; the PC update from the UPDATE cycle is visible on pc_addr in that REQ cycle; fetch-to-fetch minimum period is 3 cycles (REQ, ISSUE, UPDATE) with zero-wait memory and instr_ready held high.
REQ-021 A 1 on halt_req in any non-IDLE state SHALL set a sticky halt flag; UPDATE with the flag set still issues its pc_drive, then goes to HALT instead of REQ.
REQ-022 HALT SHALL be left only by reset; start is ignored there.
REQ-023 busy=1 in REQ, WAIT, ISSUE, UPDATE; 0 in IDLE, HALT.
REQ-024 PC arithmetic, including wrap-around, belongs to the PC block; the sequencer SHALL forward br_target unmodified.

Reset
REQ-025 rst=0 SHALL immediately force IDLE, pc_drive=000, pc_set=0, mem_req=0, mem_addr=0, instr=0, instr_valid=0, busy=0, fault=0 and clear the pending-branch and halt flags, including mid-transaction; a late mem_ack after reset is ignored.
REQ-026 rst deassertion SHALL take effect on the following clk edge; no fetch occurs until start.

Configuration
REQ-027 Macro FETCH_TIMEOUT_EN defined: an 8-bit counter clears on REQ entry and increments each WAIT cycle without mem_ack; at count 255, fault=1 (sticky until reset), mem_req=0, state -> HALT, no pc_drive issued.
REQ-028 FETCH_TIMEOUT_EN undefined: WAIT persists indefinitely, no counter is present, and fault is constant 0.

Verification
REQ-029 Reset release, start=1, pc_addr=0, mem_ack same cycle, data 0xA5A5A5A5, instr_ready=1 -> instr=0xA5A5A5A5 valid one cycle, then pc_drive=001 for exactly one cycle, next mem_addr=1.
REQ-030 mem_ack delayed 4 cycles, instr_ready low 3 cycles -> mem_req high 5 cycles, mem_addr held, instr stable while valid, single pc_drive pulse.
REQ-031 br_req=1, br_rel=0, br_target=0x100 at handshake -> pc_drive=011, pc_set=0x100; br_rel=1, br_target=0xFFFFFFFC -> pc_drive=100, pc_set=0xFFFFFFFC.
REQ-032 halt_req pulse during WAIT -> fetch completes, pc_drive=001 issued, state HALT, busy=0; start ignored afterwards.
REQ-033 rst low during WAIT with mem_ack arriving the next cycle -> mem_req=0 immediately, instr_valid stays 0, IDLE held.
REQ-034 FETCH_TIMEOUT_EN defined, mem_ack never asserted -> fault=1 after 255 WAIT cycles, mem_req=0, busy=0; undefined -> mem_req still 1 after 1000 cycles.
